tff_toggle_sched: RTL and testbench

//  Round-robin scheduler sharing one bank of WIDTH T flip-flops between NREQ requesters.

---
 rtl/tff_toggle_sched_pkg.sv | 15 +
 rtl/tff_toggle_sched_bank.sv | 25 ++
 rtl/tff_toggle_sched.sv | 128 ++++++++++++
 tb/tb_tff_toggle_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tff_toggle_sched_pkg.sv
// Shared definitions for the T flip-flop toggle scheduler: FSM encoding and
// default parameter values.
package tff_toggle_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TOGGLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/tff_toggle_sched_bank.sv
// Bank of WIDTH T flip-flops; each bit flips on a clock edge where its T input is 1.
module tff_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tff
    always_ff @(posedge clk) begin
      if (reset) begin
        r_q[gi] <= 1'b0;
      end else begin
        r_q[gi] <= r_q[gi] ^ t[gi];
      end
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tff_toggle_sched.sv
// Round-robin scheduler that lends one shared T flip-flop bank to NREQ
// requesters, applying the winner's mask for 'count' consecutive cycles.
module tff_toggle_sched
  import tff_toggle_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  input  logic [NREQ*CNT_W-1:0] count,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      t_out,
  output logic [WIDTH-1:0]      q
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_win;
  logic [WIDTH-1:0] r_mask_l;
  logic [CNT_W-1:0] r_rem;

  logic [IDX_W-1:0] w_pick;
  logic [WIDTH-1:0] w_pick_mask;
  logic [CNT_W-1:0] w_pick_cnt;
  logic [NREQ-1:0]  w_pick_onehot;
  logic [IDX_W-1:0] w_ptr_next;
  logic [WIDTH-1:0] w_t;

  // First set request at or above p, wrapping around past NREQ-1.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_pick        = rr_pick(req, r_ptr);
  assign w_pick_mask   = mask[int'(w_pick)*WIDTH +: WIDTH];
  assign w_pick_cnt    = count[int'(w_pick)*CNT_W +: CNT_W];
  assign w_pick_onehot = NREQ'(1) << w_pick;
  assign w_ptr_next    = (r_win == IDX_W'(NREQ - 1)) ? '0 : r_win + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_done   <= '0;
      r_ptr    <= '0;
      r_win    <= '0;
      r_mask_l <= '0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= '0;
          if (|req) begin
            r_win    <= w_pick;
            r_gnt    <= w_pick_onehot;
            r_mask_l <= w_pick_mask;
            r_rem    <= w_pick_cnt;
            // A zero-length job skips the bank entirely and goes straight to done.
            if (w_pick_cnt == '0) begin
              r_state <= S_DONE;
              r_done  <= w_pick_onehot;
            end else begin
              r_state <= S_TOGGLE;
            end
          end
        end
        S_TOGGLE: begin
          r_rem <= r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= r_gnt;
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_ptr   <= w_ptr_next;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_t = (r_state == S_TOGGLE) ? r_mask_l : '0;

  tff_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .t     (w_t),
    .q     (q)
  );

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign busy  = (r_state != S_IDLE);
  assign t_out = w_t;

endmodule

// File: tb/tb_tff_toggle_sched.sv
// Directed bench for tff_toggle_sched: jobs push expected completions onto a
// scoreboard that is popped whenever a done pulse appears.
module tb_tff_toggle_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] mask = '0;
  logic [15:0] count = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  t_out;
  logic [7:0]  q;

  typedef struct {
    int         idx;
    logic [7:0] q;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   gcycles = 0;

  always #5 clk = ~clk;

  tff_toggle_sched #(
    .NREQ  (4),
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .mask  (mask),
    .count (count),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .t_out (t_out),
    .q     (q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done === 4'b0 && n < 20);
    check("wait_done", 32'(done != 4'b0), 32'd1);
  endtask

  // Completion monitor: each done pulse must match the oldest expected job.
  always @(negedge clk) begin
    if (done !== 4'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_vec", 32'(done), 32'(1 << mon_e.idx));
        check("gnt_at_done", 32'(gnt), 32'(1 << mon_e.idx));
        check("q_at_done", 32'(q), 32'(mon_e.q));
        check("toggle_cycles", 32'(gcycles), 32'(mon_e.cnt));
      end
      gcycles = 0;
    end else if (gnt !== 4'b0) begin
      gcycles++;
    end else begin
      gcycles = 0;
    end
  end

  initial begin
    // 1) reset, then quiet idle
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_gnt", 32'(gnt), 32'd0);
      check("t1_done", 32'(done), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_q", 32'(q), 32'd0);
      check("t1_t_out", 32'(t_out), 32'd0);
    end

    // 2) single job, odd count
    mask[7:0]  = 8'hA5;
    count[3:0] = 4'd3;
    req        = 4'b0001;
    sb.push_back('{0, 8'hA5, 3});
    tick();
    req = 4'b0000;
    check("t2_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      check("t2_t_out", 32'(t_out), 32'hA5);
      tick();
    end
    check("t2_q", 32'(q), 32'hA5);
    check("t2_t_out_done", 32'(t_out), 32'd0);
    tick();
    check("t2_busy", 32'(busy), 32'd0);

    // 3) all four requesting, served in rotation from requester 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t3_q_reset", 32'(q), 32'd0);
    mask  = {8'h08, 8'h04, 8'h02, 8'h01};
    count = {4'd1, 4'd1, 4'd1, 4'd1};
    sb.push_back('{0, 8'h01, 1});
    sb.push_back('{1, 8'h03, 1});
    sb.push_back('{2, 8'h07, 1});
    sb.push_back('{3, 8'h0F, 1});
    sb.push_back('{0, 8'h0E, 1});
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done();
    end
    req = 4'b0000;
    wait_idle();
    check("t3_q_final", 32'(q), 32'h0E);

    // 4) zero-count job for requester 1: done only, bank untouched
    mask[15:8] = 8'hFF;
    count[7:4] = 4'd0;
    req        = 4'b0010;
    sb.push_back('{1, 8'h0E, 0});
    tick();
    req = 4'b0000;
    check("t4_gnt", 32'(gnt), 32'h2);
    check("t4_t_out", 32'(t_out), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    tick();
    check("t4_busy_after", 32'(busy), 32'd0);
    check("t4_gnt_after", 32'(gnt), 32'd0);
    check("t4_t_out_after", 32'(t_out), 32'd0);
    check("t4_q", 32'(q), 32'h0E);

    // 5) reset during the 4th toggle cycle aborts the job
    mask[23:16] = 8'hFF;
    count[11:8] = 4'd8;
    req         = 4'b0100;
    tick();
    req = 4'b0000;
    check("t5_gnt", 32'(gnt), 32'h4);
    repeat (3) tick();
    check("t5_q_mid", 32'(q), 32'hF1);
    check("t5_t_out_mid", 32'(t_out), 32'hFF);
    reset = 1'b1;
    tick();
    check("t5_q_rst", 32'(q), 32'd0);
    check("t5_gnt_rst", 32'(gnt), 32'd0);
    check("t5_busy_rst", 32'(busy), 32'd0);
    check("t5_done_rst", 32'(done), 32'd0);
    check("t5_t_out_rst", 32'(t_out), 32'd0);
    reset = 1'b0;
    repeat (12) tick();
    check("t5_no_replay_busy", 32'(busy), 32'd0);
    check("t5_no_replay_q", 32'(q), 32'd0);

    // 6) job inputs change and req drops mid-job; pointer then moves to 3
    mask[23:16] = 8'h3C;
    count[11:8] = 4'd5;
    req         = 4'b0100;
    sb.push_back('{2, 8'h3C, 5});
    tick();
    check("t6_gnt", 32'(gnt), 32'h4);
    tick();
    req         = 4'b0000;
    mask[23:16] = 8'hFF;
    count[11:8] = 4'd2;
    wait_idle();
    check("t6_q", 32'(q), 32'h3C);
    mask[31:24]  = 8'h01;
    count[15:12] = 4'd1;
    mask[7:0]    = 8'h80;
    count[3:0]   = 4'd1;
    req          = 4'b1001;
    sb.push_back('{3, 8'h3D, 1});
    tick();
    check("t6_ptr_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    wait_idle();
    check("t6_q_final", 32'(q), 32'h3D);

    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
